// File: rtl/sw_alloc_if.sv
// Flit heads in, crossbar selects and FIFO pop strobes out, for the 4x4 switch allocator.
// Latency: none, this is wiring only.
// Backpressure: ack pops the input FIFO; an input without ack holds its head flit.
interface sw_alloc_if #(
    parameter int PKTW = 9
);
    logic [PKTW:0] i0;
    logic [PKTW:0] i1;
    logic [PKTW:0] i2;
    logic [PKTW:0] i3;
    logic [3:0]    d0;
    logic [3:0]    d1;
    logic [3:0]    d2;
    logic [3:0]    d3;
    logic          ack0;
    logic          ack1;
    logic          ack2;
    logic          ack3;
`ifdef SW_ALLOC_TIMEOUT_EN
    logic          tout_err;

    modport master (
        output i0, i1, i2, i3,
        input  d0, d1, d2, d3, ack0, ack1, ack2, ack3, tout_err
    );
    modport slave (
        input  i0, i1, i2, i3,
        output d0, d1, d2, d3, ack0, ack1, ack2, ack3, tout_err
    );
`else
    modport master (
        output i0, i1, i2, i3,
        input  d0, d1, d2, d3, ack0, ack1, ack2, ack3
    );
    modport slave (
        input  i0, i1, i2, i3,
        output d0, d1, d2, d3, ack0, ack1, ack2, ack3
    );
`endif
endinterface

// File: rtl/sw_alloc.sv
// Wormhole switch allocator for a 4x4 crossbar, round-robin per output; optional idle watchdog under SW_ALLOC_TIMEOUT_EN.
// Latency: head at cycle t gives d_k/ack_j at t+1; tail releases at the next edge, so one bubble per packet.
// Backpressure: ack_j is combinational; losing or stray inputs see ack=0 and keep their head flit.
module sw_alloc #(
    parameter int PKTW = 9,
    parameter int TOUT = 16
) (
    input  logic     clk,
    input  logic     rst,
    sw_alloc_if.slave bus
);

    typedef enum logic [1:0] {
        FT_IDLE = 2'b00,
        FT_BODY = 2'b01,
        FT_HEAD = 2'b10,
        FT_TAIL = 2'b11
    } ftype_e;

    typedef enum logic {
        OUT_FREE = 1'b0,
        OUT_BUSY = 1'b1
    } out_st_e;

    logic [PKTW:0] flit [4];
    ftype_e        ftype [4];
    logic [1:0]    fdst [4];

    out_st_e       ost_q [4];
    out_st_e       ost_d [4];
    logic [1:0]    gnt_q [4];
    logic [1:0]    gnt_d [4];
    logic [1:0]    ptr_q [4];
    logic [1:0]    ptr_d [4];

    logic [3:0]    in_gnt;
    logic [3:0]    ack;
    logic [3:0]    req [4];
    logic [3:0]    win_vld;
    logic [1:0]    win [4];
    logic [3:0]    rel;
    logic [3:0]    d [4];

    assign flit[0] = bus.i0;
    assign flit[1] = bus.i1;
    assign flit[2] = bus.i2;
    assign flit[3] = bus.i3;

    // Source field and upper destination bits carry no routing meaning here.
    logic unused_payload;
    assign unused_payload = ^{flit[0][PKTW-2:2], flit[1][PKTW-2:2],
                              flit[2][PKTW-2:2], flit[3][PKTW-2:2]};

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            ftype[j] = ftype_e'(flit[j][PKTW:PKTW-1]);
            fdst[j]  = flit[j][1:0];
        end
    end

    always_comb begin
        in_gnt = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (ost_q[k] == OUT_BUSY) begin
                in_gnt[gnt_q[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            ack[j] = in_gnt[j] && (ftype[j] != FT_IDLE) && !rst;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                req[k][j] = (ftype[j] == FT_HEAD) && (fdst[j] == 2'(k)) && !in_gnt[j];
            end
        end
    end

    // Scan from ptr+3 down to ptr so the candidate closest to ptr is written last and wins.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            win_vld[k] = 1'b0;
            win[k]     = 2'b00;
            for (int off = 3; off >= 0; off--) begin
                if (req[k][2'(ptr_q[k] + 2'(off))]) begin
                    win_vld[k] = 1'b1;
                    win[k]     = 2'(ptr_q[k] + 2'(off));
                end
            end
        end
    end

`ifdef SW_ALLOC_TIMEOUT_EN
    localparam int CW = $clog2(TOUT + 1);

    logic [CW-1:0] idle_cnt_q [4];
    logic [3:0]    tmo_hit;
    logic          tout_err_q;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tmo_hit[k] = (ost_q[k] == OUT_BUSY) && (ftype[gnt_q[k]] == FT_IDLE) &&
                         (idle_cnt_q[k] == CW'(TOUT - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tout_err_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                idle_cnt_q[k] <= '0;
            end
        end else begin
            tout_err_q <= tout_err_q | (|tmo_hit);
            for (int k = 0; k < 4; k++) begin
                if (ost_q[k] != OUT_BUSY || ack[gnt_q[k]] || tmo_hit[k]) begin
                    idle_cnt_q[k] <= '0;
                end else if (ftype[gnt_q[k]] == FT_IDLE) begin
                    idle_cnt_q[k] <= idle_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign bus.tout_err = tout_err_q;
`else
    localparam int tout_unused = TOUT;
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rel[k] = ack[gnt_q[k]] && (ftype[gnt_q[k]] == FT_TAIL);
`ifdef SW_ALLOC_TIMEOUT_EN
            // Forced release leaves the pointer where the last real grant put it.
            rel[k] = rel[k] || tmo_hit[k];
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ost_d[k] = ost_q[k];
            gnt_d[k] = gnt_q[k];
            ptr_d[k] = ptr_q[k];
            case (ost_q[k])
                OUT_FREE: begin
                    if (win_vld[k]) begin
                        ost_d[k] = OUT_BUSY;
                        gnt_d[k] = win[k];
                        ptr_d[k] = win[k] + 2'd1;
                    end
                end
                OUT_BUSY: begin
                    if (rel[k]) begin
                        ost_d[k] = OUT_FREE;
                    end
                end
                default: ost_d[k] = OUT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                ost_q[k] <= OUT_FREE;
                gnt_q[k] <= 2'b00;
                ptr_q[k] <= 2'b00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                ost_q[k] <= ost_d[k];
                gnt_q[k] <= gnt_d[k];
                ptr_q[k] <= ptr_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            d[k] = (ost_q[k] == OUT_BUSY) ? (4'b0001 << gnt_q[k]) : 4'b0000;
        end
    end

    assign bus.d0   = d[0];
    assign bus.d1   = d[1];
    assign bus.d2   = d[2];
    assign bus.d3   = d[3];
    assign bus.ack0 = ack[0];
    assign bus.ack1 = ack[1];
    assign bus.ack2 = ack[2];
    assign bus.ack3 = ack[3];

endmodule

// File: doc/sw_alloc.md
Name: sw_alloc

Overview:
- Switch allocator directly upstream of the 4x4 crossbar `cb`.
- Watches the head flit presented by each of the four input FIFOs and arbitrates each output port round-robin.
- Drives the crossbar select vectors d0..d3 and per-input pop strobes ack0..ack3.
- Holds each connection from head flit to tail flit (wormhole), then releases it.

Parameters:
- PKTW, 9: MSB index of a flit. Flit = [PKTW:PKTW-1] type + [PKTW-2:0] payload; matches `PKTW` in sw.vh.
- TOUT, 16: idle-cycle limit for the optional watchdog; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i0..i3  in  PKTW+1 each  flit at head of input FIFO n (same bus as crossbar input n)
- d0..d3  out  4 each  select for output k; bit j=1 connects input j to output k; one-hot or zero
- ack0..ack3  out  1 each  pop strobe to input FIFO n; flit on i_n is consumed this cycle

Behaviour:
- Flit type field [PKTW:PKTW-1]:
  - 00 = empty/idle
  - 10 = head
  - 01 = body
  - 11 = tail
- Head payload bits [3:0] = destination; port index = bits [1:0], bits [3:2] ignored. Bits [7:4] = source, ignored.
- Reset: d0..d3 = 0, ack0..ack3 = 0, all round-robin pointers = 0, all grants cleared. Reset mid-packet drops the connection; no flit is acked in the reset cycle.
- Request: input j requests output k when i_j type = 10, dst = k, and input j holds no grant.
- Grant, cycle t: for each output k with no grant, choose among requesters starting at pointer ptr_k, then ptr_k+1, ... mod 4.
  - Register grant g[k] = j; d_k bit j = 1 from t+1.
  - ptr_k <= (j+1) mod 4.
  - Latency: head visible at t -> d_k/ack_j high at t+1.
- An input can receive at most one grant per cycle. Requests target a single output, so no input-side conflict arises.
- ack_j is combinational: ack_j = (input j holds a grant) && (i_j type != 00). The flit passes through `cb` in the same cycle.
- Release: when ack_j = 1 and i_j type = 11, clear the grant at the next edge; d_k = 0 from t+1.
  - Requests arriving in the release cycle are arbitrated at t+1 and granted at t+2. One bubble per packet is required.
- Idle (00) flits under a grant keep the grant; no ack.
- Body or tail flit at an input with no grant is a protocol error: not acked, never granted, held in place.
- Losing requesters keep their head flit (ack = 0) and re-request every cycle.
- Output mutual exclusion: d_k has at most one bit set at all times. No two d_k share a set bit.

Optional Feature:
- Macro: SW_ALLOC_TIMEOUT_EN.
- Defined: per-output counter counts consecutive granted cycles with type 00 on the granted input; resets on any acked flit.
  - On reaching TOUT the grant is force-released at the next edge, and sticky output `tout_err` (1 bit, port added only when defined) goes to 1 until rst.
  - ptr_k is unchanged by forced release.
- Undefined: no counters, no tout_err port; a stalled packet holds its output indefinitely.

Test Plan:
- Reset then idle: all i = 0 for 5 cycles -> d0..d3 = 0, ack = 0.
- Single packet: i0 = 10_0000_0001, 01_..., 01_..., 11_... -> d1 = 0001 from the cycle after the head. ack0 high for 4 flits. d1 = 0 the cycle after the tail.
- Four-way conflict on output 1: all inputs head to dst 1 at once, pointer 0 -> grant order in0, in1, in2, in3. Each packet is 4 flits with one bubble between them. Losers' ack = 0 until granted.
- Round-robin rotation: after the above, repeat the conflict for dst 1 -> in0 wins first again (ptr_1 = 0 after in3). Repeat with only in2 and in3 -> in2 first.
- Parallel non-conflicting: in0->2, in1->3, in2->0, in3->1 same cycle -> d2 = 0001, d3 = 0010, d0 = 0100, d1 = 1000 together, all acks high.
- Stray and reset: body flit on i1 with no grant -> ack1 = 0, no d change. rst asserted mid-packet -> next cycle all d/ack = 0. With SW_ALLOC_TIMEOUT_EN and TOUT = 16: head then 16 idle cycles -> grant dropped, tout_err = 1.
